// File: rtl/pixel_stream_editor.sv
// Two-stage streaming pixel editor (pass/brighten/darken/threshold/invert) with frame tracking.
// Optional per-frame min/max statistics are enabled by defining STATS_EN.
module pixel_stream_editor #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 98304,
  parameter int CNT_W        = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cfg_mode,
  input  logic [PIX_W-1:0] cfg_value,
  input  logic [PIX_W-1:0] cfg_threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             frame_done
`ifdef STATS_EN
  ,
  output logic [PIX_W-1:0] frame_min,
  output logic [PIX_W-1:0] frame_max
`endif
);

  localparam logic [PIX_W-1:0] PMAX     = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  localparam logic [2:0] MODE_BRIGHTEN  = 3'd1;
  localparam logic [2:0] MODE_DARKEN    = 3'd2;
  localparam logic [2:0] MODE_THRESHOLD = 3'd3;
  localparam logic [2:0] MODE_INVERT    = 3'd4;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The whole pipe advances together whenever the output register is empty or being drained.
  logic adv;
  logic accept;
  logic out_hs;

  logic [CNT_W-1:0] pix_cnt;

  logic [2:0]       sh_mode;
  logic [PIX_W-1:0] sh_value;
  logic [PIX_W-1:0] sh_thr;

  logic             s1_valid;
  logic [PIX_W-1:0] s1_pixel;
  logic             s1_last;

  logic             s2_valid;
  logic [PIX_W-1:0] s2_pixel;
  logic             s2_last;

  logic [PIX_W:0]   sum;
  logic [PIX_W-1:0] result;

  assign adv      = !s2_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign out_hs   = s2_valid && out_ready;

  assign out_valid = s2_valid;
  assign out_pixel = s2_pixel;
  assign out_last  = s2_last;

  // Frame position counter; the pixel at the wrap point carries the last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (accept) begin
      if (pix_cnt == LAST_CNT) begin
        pix_cnt <= '0;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // Config is latched with pixel 0; the pixel ahead of it in S1 still sees the old values
  // because its result is registered on this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode  <= '0;
      sh_value <= '0;
      sh_thr   <= '0;
    end else if (accept && (pix_cnt == '0)) begin
      sh_mode  <= cfg_mode;
      sh_value <= cfg_value;
      sh_thr   <= cfg_threshold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pixel <= '0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pixel <= in_pixel;
        s1_last  <= (pix_cnt == LAST_CNT);
      end
    end
  end

  always_comb begin
    sum    = {1'b0, s1_pixel} + {1'b0, sh_value};
    result = s1_pixel;
    case (sh_mode)
      MODE_BRIGHTEN:  result = sum[PIX_W] ? PMAX : sum[PIX_W-1:0];
      MODE_DARKEN:    result = (s1_pixel > sh_value) ? (s1_pixel - sh_value) : '0;
      MODE_THRESHOLD: result = (s1_pixel >= sh_thr) ? PMAX : '0;
      MODE_INVERT:    result = PMAX - s1_pixel;
      default:        result = s1_pixel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_pixel <= '0;
      s2_last  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        s2_pixel <= result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && s2_last;
    end
  end

`ifdef STATS_EN
  logic [PIX_W-1:0] run_min;
  logic [PIX_W-1:0] run_max;
  logic [PIX_W-1:0] nxt_min;
  logic [PIX_W-1:0] nxt_max;

  always_comb begin
    nxt_min = (s2_pixel < run_min) ? s2_pixel : run_min;
    nxt_max = (s2_pixel > run_max) ? s2_pixel : run_max;
  end

  // Trackers follow handshaken outputs; the frame result includes the last pixel itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_min   <= PMAX;
      run_max   <= '0;
      frame_min <= '0;
      frame_max <= '0;
    end else if (out_hs) begin
      if (s2_last) begin
        frame_min <= nxt_min;
        frame_max <= nxt_max;
        run_min   <= PMAX;
        run_max   <= '0;
      end else begin
        run_min <= nxt_min;
        run_max <= nxt_max;
      end
    end
  end
`endif

endmodule
